// File: rtl/bcd_scan_pkg.sv
// Shared widths, blank code and BCD-to-decimal decode for the scanned BCD display path.
package bcd_scan_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned DEC_W = 10;

  localparam logic [DEC_W-1:0] O_BLANK = 10'h3FF;

  typedef logic [BCD_W-1:0] bcd_t;

  // Active-low one-of-ten decode; codes 10..15 light nothing, like the SN74145.
  function automatic logic [DEC_W-1:0] bcd_to_dec_n(input bcd_t code);
    if (code > 4'd9) return O_BLANK;
    return ~(DEC_W'(1) << code);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Dwell prescaler and digit index for the scan; flags dwell end, frame end and the blank cycle.
module scan_timer #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 16,
  parameter int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] index,
  output logic             tc,
  output logic             wrap,
  output logic             is_blank
);

  localparam int unsigned PS_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PS_W-1:0]  presc_q;
  logic [IDX_W-1:0] index_q;

  assign index    = index_q;
  assign tc       = (presc_q == PS_W'(SCAN_DIV - 1));
  assign wrap     = tc && (index_q == IDX_W'(DIGITS - 1));
  assign is_blank = (presc_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      index_q <= '0;
    end else if (tc) begin
      presc_q <= '0;
      index_q <= wrap ? '0 : IDX_W'(index_q + 1'b1);
    end else begin
      presc_q <= PS_W'(presc_q + 1'b1);
    end
  end

endmodule

// File: rtl/bcd_scan_decoder.sv
// Multiplexed BCD-to-decimal display driver with frame-synchronous data commit.
// Optional LEADING_ZERO_BLANK_EN: blank zero digits above the most significant non-zero digit.
module bcd_scan_decoder
  import bcd_scan_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 16,
  parameter int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [BCD_W*DIGITS-1:0] load_data,
  output logic [DEC_W-1:0]        o,
  output logic [DIGITS-1:0]       sel,
  output logic                    bad_code,
  output logic                    frame_start
);

  bcd_t [DIGITS-1:0] load_digits;
  bcd_t [DIGITS-1:0] pend_q;
  bcd_t [DIGITS-1:0] disp_q;
  logic              pend_flag_q;

  logic [IDX_W-1:0]  index;
  logic              tc_unused;
  logic              wrap;
  logic              is_blank;
  logic              xfer_c;
  logic              bad_c;
  logic              digit_blank_c;

  scan_timer #(
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV),
    .IDX_W   (IDX_W)
  ) u_scan_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .index   (index),
    .tc      (tc_unused),
    .wrap    (wrap),
    .is_blank(is_blank)
  );

  assign load_digits = load_data;
  assign load_ready  = ~pend_flag_q;
  assign xfer_c      = load_valid && !pend_flag_q;

  always_comb begin
    bad_c = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (load_digits[k] > 4'd9) bad_c = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz_blank_c;
  logic              nz_seen_c;

  // Walk down from the top digit; blank while every digit so far is zero. Digit 0 always shows.
  always_comb begin
    lz_blank_c = '0;
    nz_seen_c  = 1'b0;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      nz_seen_c     = nz_seen_c | (disp_q[k] != '0);
      lz_blank_c[k] = !nz_seen_c;
    end
  end

  assign digit_blank_c = lz_blank_c[index];
`else
  assign digit_blank_c = 1'b0;
`endif

  // Handshake into the pending buffer; swap into the display only at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      disp_q      <= '0;
      pend_flag_q <= 1'b0;
      bad_code    <= 1'b0;
    end else begin
      bad_code <= xfer_c && bad_c;
      if (xfer_c) begin
        pend_q      <= load_digits;
        pend_flag_q <= 1'b1;
      end else if (wrap && pend_flag_q) begin
        disp_q      <= pend_q;
        pend_flag_q <= 1'b0;
      end
    end
  end

  // Output stage lags the scan state by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o           <= O_BLANK;
      sel         <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= is_blank && (index == '0);
      if (is_blank) begin
        o   <= O_BLANK;
        sel <= '1;
      end else begin
        o   <= digit_blank_c ? O_BLANK : bcd_to_dec_n(disp_q[index]);
        sel <= ~(DIGITS'(1) << index);
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// Randomised self-checking bench for bcd_scan_decoder against a cycle-count based reference model.
module tb_bcd_scan_decoder;

  localparam int unsigned D  = 4;
  localparam int unsigned SD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_valid;
  logic          load_ready;
  logic [15:0]   load_data;
  logic [9:0]    o;
  logic [3:0]    sel;
  logic          bad_code;
  logic          frame_start;

  int checks = 0;
  int passes = 0;

  // Reference model: scan position comes from the cycle count since reset release.
  int          cyc;
  bit          m_pend;
  logic [15:0] m_pdata;
  logic [15:0] m_disp;
  logic [9:0]  e_o;
  logic [3:0]  e_sel;
  bit          e_bad;
  bit          e_fs;

  bcd_scan_decoder #(.DIGITS(D), .SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .o          (o),
    .sel        (sel),
    .bad_code   (bad_code),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [9:0] exp_code(input logic [15:0] disp, input int k);
    logic [15:0] upper;
    int v;
    upper = disp >> (4 * k);
    v = int'(upper & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && upper == 16'h0) return 10'h3FF;
`endif
    if (v > 9) return 10'h3FF;
    return 10'h3FF ^ (10'd1 << v);
  endfunction

  function automatic bit any_bad(input logic [15:0] d);
    for (int i = 0; i < int'(D); i++)
      if (((d >> (4 * i)) & 16'hF) > 16'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] d;
    for (int i = 0; i < int'(D); i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
    return d;
  endfunction

  task automatic model_reset();
    cyc = 0; m_pend = 0; m_pdata = '0; m_disp = '0;
    e_o = 10'h3FF; e_sel = 4'hF; e_bad = 0; e_fs = 0;
  endtask

  task automatic model_step(input bit v, input logic [15:0] d);
    int  presc, idx;
    bit  blank, xfer;
    presc = cyc % int'(SD);
    idx   = (cyc / int'(SD)) % int'(D);
    blank = (presc == 0);
    xfer  = v && !m_pend;
    e_bad = xfer && any_bad(d);
    e_fs  = blank && (idx == 0);
    e_o   = blank ? 10'h3FF : exp_code(m_disp, idx);
    e_sel = blank ? 4'hF : 4'(~(1 << idx));
    if (xfer) begin
      m_pend = 1; m_pdata = d;
    end else if (presc == int'(SD) - 1 && idx == int'(D) - 1 && m_pend) begin
      m_disp = m_pdata; m_pend = 0;
    end
    cyc++;
  endtask

  task automatic check_outputs();
    check_eq("o", 32'(o), 32'(e_o));
    check_eq("sel", 32'(sel), 32'(e_sel));
    check_eq("load_ready", 32'(load_ready), 32'(!m_pend));
    check_eq("bad_code", 32'(bad_code), 32'(e_bad));
    check_eq("frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  // Called at a falling edge: drive, clock, then sample at the next falling edge.
  task automatic run_cycle(input bit v, input logic [15:0] d);
    load_valid = v;
    load_data  = d;
    @(posedge clk);
    model_step(v, d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic load_frame(input logic [15:0] d);
    for (int n = 0; n < 64 && !load_ready; n++) run_cycle(1'b0, 16'($urandom));
    check_eq("ready_wait", 32'(load_ready), 32'd1);
    run_cycle(1'b1, d);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_o", 32'(o), 32'h3FF);
    check_eq("rst_sel", 32'(sel), 32'hF);
    check_eq("rst_ready", 32'(load_ready), 32'd1);
    check_eq("rst_bad", 32'(bad_code), 32'd0);
    check_eq("rst_fs", 32'(frame_start), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs();
    end
    rst_n = 1'b1;

    repeat (20) run_cycle(1'b0, '0);
    load_frame(16'h1234);
    repeat (40) run_cycle(1'b0, 16'($urandom));
    load_frame(16'h00A5);
    repeat (40) run_cycle(1'b0, 16'($urandom));
`ifdef LEADING_ZERO_BLANK_EN
    load_frame(16'h0070);
    repeat (36) run_cycle(1'b0, '0);
    load_frame(16'h0000);
    repeat (36) run_cycle(1'b0, '0);
`endif

    repeat (80) run_cycle(1'b1, rand_bcd());

    repeat (300) begin
      if ($urandom_range(0, 1) == 0) run_cycle($urandom_range(0, 3) == 0, rand_bcd());
      else run_cycle($urandom_range(0, 3) == 0, 16'($urandom));
    end

    // Asynchronous reset in the digit-2 dwell while a frame is pending.
    for (int n = 0; n < 100; n++) begin
      if (m_pend && ((cyc / int'(SD)) % int'(D)) == 2) break;
      run_cycle(1'b1, rand_bcd());
    end
    check_eq("pend_before_rst", 32'(load_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    load_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs();
    end
    rst_n = 1'b1;
    repeat (24) run_cycle(1'b0, '0);
    repeat (100) run_cycle($urandom_range(0, 2) == 0, rand_bcd());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bcd_scan_decoder.md
Name: bcd_scan_decoder

Overview:
- Parametrised, clocked successor to the team's SN74145 BCD-to-decimal decoder.
- Holds DIGITS BCD digits and time-multiplexes them onto one shared active-low 10-line decimal bus, with an active-low one-hot digit select.
- Inserts a blanking cycle between digits to prevent ghosting.
- Defers new display data to a frame boundary so a frame never tears.
- Sits between the core logic and a multiplexed nixie/lamp display driver.

Parameters:
- DIGITS, 4: number of BCD digits scanned (1..16).
- SCAN_DIV, 16: clock cycles per digit dwell, blank cycle included (2..65536).
- IDX_W, $clog2(DIGITS) (minimum 1): derived digit-index width; not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- load_valid  input  1  new frame data present.
- load_ready  output  1  block can accept a frame.
- load_data  input  4*DIGITS  BCD digits; digit k = load_data[4k+3:4k]; digit 0 scans first.
- o  output  10  decimal lines, active low; o[n]=0 means digit value n is lit.
- sel  output  DIGITS  digit enables, active low, one-hot or all high.
- bad_code  output  1  one-cycle pulse when an accepted frame contains any nibble >9.
- frame_start  output  1  one-cycle pulse coinciding with the blank cycle of digit 0.

Behaviour:
- Reset is asynchronous and active-low.
  - While rst_n=0: o=10'h3FF, sel=all 1, load_ready=1, bad_code=0, frame_start=0.
  - Internal state while rst_n=0: prescaler=0, index=0, display register=0, pending register=0, pending flag=0.
  - Reset mid-scan or mid-handshake discards all data.
- Prescaler counts 0..SCAN_DIV-1 and wraps.
- Index increments when the prescaler is at SCAN_DIV-1; it wraps DIGITS-1 -> 0.
- Outputs are registered and lag the (index, prescaler) state by exactly one clock.
- Blank cycle: when the registered prescaler state was 0, o=10'h3FF and sel=all 1.
- Otherwise:
  - sel = ~(1<<index).
  - o = ~(1<<digit) for a digit value 0..9.
  - o = 10'h3FF for codes 10..15, matching SN74145 invalid-code behaviour.
- Handshake: a transfer occurs when load_valid && load_ready on a rising edge.
  - The transfer captures load_data into the pending register and sets the pending flag.
  - load_ready = !pending.
  - load_data must be held stable only in the transfer cycle.
- Commit: when the index wraps to 0 (prescaler=SCAN_DIV-1 and index=DIGITS-1) and pending=1:
  - the pending register copies to the display register;
  - the pending flag clears, so load_ready returns to 1 the next cycle.
- Simultaneous transfer and commit cannot occur, because ready=0 while pending.
- A transfer in the exact wrap cycle with pending=0 commits at the next wrap, not the current one.
- bad_code pulses in the cycle after the transfer. Bad digits are still stored and display as blank.
- frame_start is registered alongside o and sel.
- DIGITS=1: index is constant 0, and every dwell is a frame.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined:
  - Digits above the highest non-zero digit that hold value 0 are displayed blank (o=10'h3FF, sel still driven).
  - Digit 0 is never blanked, so 16'h0000 shows "0".
  - Blanking is evaluated on the display register.
- When undefined: all digits are always shown, and no extra logic is present.

Decomposition:
- Package bcd_scan_pkg holds:
  - BCD_W=4 and DEC_W=10;
  - O_BLANK=10'h3FF;
  - typedef bcd_t (logic [3:0]);
  - function bcd_to_dec_n(bcd_t) returning the active-low 10-bit code.
- One natural sub-module, scan_timer: owns prescaler and index, and emits tc (dwell end), wrap (frame end) and is_blank.
- The top keeps the handshake, the registers and the output decode.

Test Plan (DIGITS=4, SCAN_DIV=4):
- Reset held, then released with no load -> o=10'h3FF, sel=4'hF, load_ready=1. First frame shows 0 on each digit (o=10'h3FE), preceded by one blank cycle per digit.
- Load 16'h1234 -> load_ready drops the next cycle and the current frame finishes unchanged.
  - After the wrap: digit0 shows o=10'h3EF with sel=4'b1110.
  - Then digit1: o=10'h3F7, sel=4'b1101. Then digit2: o=10'h3FB. Then digit3: o=10'h3FD.
  - load_ready=1 again after the commit.
- Load 16'h00A5 -> bad_code pulses once. Digit1 (A) shows o=10'h3FF; digit0 shows o=10'h3DF.
- Hold load_valid high continuously -> exactly one transfer per frame. The second frame is held until its wrap, with no tearing inside a frame.
- Assert rst_n=0 during digit2 dwell with pending=1 -> outputs blank immediately. After release, digits show 0 and load_ready=1.
- Feature: with LEADING_ZERO_BLANK_EN, load 16'h0070 -> digits 3 and 2 blank, digit1 shows 7, digit0 shows 0. Load 16'h0000 -> only digit0 shows 0.
